seg_scan_ctrl: RTL and testbench

Time-multiplexed scan scheduler for an NDIG-digit common-segment seven-segment display. It shares the single 7-segment + DP output bus between digits, inserting a dead-time blank between digit slots to suppress ghosting. New display values arrive through a valid/ready handshake and are committed only at frame boundaries, so a frame never shows a mix of old and new digits. It sits between the counter/value datapath and the `uo_out`/`uio_out` pads of the top level.

---
 rtl/seg_scan_ctrl.sv | 140 ++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan scheduler for an NDIG-digit seven-segment display.
// Values load through valid/ready and are committed only at frame boundaries.
module seg_scan_ctrl #(
   parameter int unsigned NDIG     = 4,
   parameter int unsigned PRESCALE = 2500,
   parameter int unsigned BLANK    = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [4*NDIG-1:0] value_in,
   input  logic [NDIG-1:0]   dp_in,
   input  logic              load_valid,
   output logic              load_ready,
   input  logic              lzb_en,
   output logic [6:0]        seg_out,
   output logic              dp_out,
   output logic [NDIG-1:0]   dig_en,
   output logic              frame_tick
);

   localparam int unsigned P_W = $clog2(PRESCALE);
   localparam int unsigned D_W = $clog2(NDIG);
   localparam int unsigned V_W = 4 * NDIG;

   typedef enum logic {
      S_BLANK = 1'b0,
      S_SHOW  = 1'b1
   } slot_t;

   slot_t             slot;
   logic [P_W-1:0]    p;
   logic [D_W-1:0]    d;
   logic [V_W-1:0]    shadow_val;
   logic [NDIG-1:0]   shadow_dp;
   logic [V_W-1:0]    pend_val;
   logic [NDIG-1:0]   pend_dp;
   logic              pending_full;

   logic              p_wrap;
   logic              frame_wrap;
   logic              accept;
   logic [3:0]        cur_nib;
   logic [NDIG-1:0]   lead_zero;
   logic              zero_above;
   logic              suppress;

   function automatic logic [6:0] hex7(input logic [3:0] n);
      case (n)
         4'h0: hex7 = 7'h3F;
         4'h1: hex7 = 7'h06;
         4'h2: hex7 = 7'h5B;
         4'h3: hex7 = 7'h4F;
         4'h4: hex7 = 7'h66;
         4'h5: hex7 = 7'h6D;
         4'h6: hex7 = 7'h7D;
         4'h7: hex7 = 7'h07;
         4'h8: hex7 = 7'h7F;
         4'h9: hex7 = 7'h6F;
         4'hA: hex7 = 7'h77;
         4'hB: hex7 = 7'h7C;
         4'hC: hex7 = 7'h39;
         4'hD: hex7 = 7'h5E;
         4'hE: hex7 = 7'h79;
         4'hF: hex7 = 7'h71;
      endcase
   endfunction

   assign p_wrap     = (p == P_W'(PRESCALE - 1));
   assign frame_wrap = p_wrap && (d == D_W'(NDIG - 1));
   assign accept     = load_valid && load_ready;
   assign cur_nib    = shadow_val[{d, 2'b00} +: 4];

   // Digit i is a leading zero when it and every more significant nibble are zero.
   always_comb begin
      lead_zero  = '0;
      zero_above = 1'b1;
      for (int i = NDIG - 1; i >= 1; i--) begin
         zero_above   = zero_above && (shadow_val[4*i +: 4] == 4'h0);
         lead_zero[i] = zero_above;
      end
   end

   assign suppress = lzb_en && lead_zero[d];

   always_ff @(posedge clk) begin
      if (reset) begin
         slot         <= S_BLANK;
         p            <= '0;
         d            <= '0;
         shadow_val   <= '0;
         shadow_dp    <= '0;
         pend_val     <= '0;
         pend_dp      <= '0;
         pending_full <= 1'b0;
         load_ready   <= 1'b1;
         seg_out      <= '0;
         dp_out       <= 1'b0;
         dig_en       <= '0;
         frame_tick   <= 1'b0;
      end else begin
         // Slot timing: blank for BLANK cycles, then lit until the prescaler wraps.
         if (p_wrap) begin
            p    <= '0;
            slot <= S_BLANK;
            d    <= (d == D_W'(NDIG - 1)) ? '0 : d + D_W'(1);
         end else begin
            p <= p + P_W'(1);
            if (p == P_W'(BLANK - 1)) begin
               slot <= S_SHOW;
            end
         end

         if (slot == S_SHOW) begin
            dig_en  <= NDIG'(1) << d;
            seg_out <= suppress ? 7'h00 : hex7(cur_nib);
            dp_out  <= shadow_dp[d];
         end else begin
            dig_en  <= '0;
            seg_out <= '0;
            dp_out  <= 1'b0;
         end

         frame_tick <= frame_wrap;

         // Accept needs an empty pending slot and commit needs a full one, so they never overlap.
         if (frame_wrap && pending_full) begin
            shadow_val   <= pend_val;
            shadow_dp    <= pend_dp;
            pending_full <= 1'b0;
            load_ready   <= 1'b1;
         end else if (accept) begin
            pend_val     <= value_in;
            pend_dp      <= dp_in;
            pending_full <= 1'b1;
            load_ready   <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: directed scenarios plus random loads, checked
// against a cycle-time reference model derived from the frame/slot arithmetic.
module tb_seg_scan_ctrl;

   localparam int NDIG  = 4;
   localparam int PRE   = 8;
   localparam int BLK   = 2;
   localparam int FRAME = NDIG * PRE;

   logic        clk;
   logic        reset;
   logic [15:0] value_in;
   logic [3:0]  dp_in;
   logic        load_valid;
   logic        load_ready;
   logic        lzb_en;
   logic [6:0]  seg_out;
   logic        dp_out;
   logic [3:0]  dig_en;
   logic        frame_tick;

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: cycle number since reset plus displayed / pending values.
   int          s;
   logic [15:0] m_shadow, m_pend;
   logic [3:0]  m_sdp, m_pdp;
   bit          m_pfull;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_dig;
   logic        e_tick;
   logic        e_ready;

   logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

   seg_scan_ctrl #(.NDIG(NDIG), .PRESCALE(PRE), .BLANK(BLK)) dut (
      .clk        (clk),
      .reset      (reset),
      .value_in   (value_in),
      .dp_in      (dp_in),
      .load_valid (load_valid),
      .load_ready (load_ready),
      .lzb_en     (lzb_en),
      .seg_out    (seg_out),
      .dp_out     (dp_out),
      .dig_en     (dig_en),
      .frame_tick (frame_tick)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_err++;
         $error("FAIL %s: observed 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, s);
      end
   endtask

   // One clock: advance the model from the inputs held this cycle, then compare all outputs.
   task automatic tick();
      logic        v_c, lz_c, rst_c;
      logic [15:0] val_c, upper;
      logic [3:0]  dp_c;
      int          pos, dig;
      v_c   = load_valid;
      lz_c  = lzb_en;
      rst_c = reset;
      val_c = value_in;
      dp_c  = dp_in;
      @(posedge clk);
      if (rst_c) begin
         s        = 0;
         m_shadow = '0;
         m_sdp    = '0;
         m_pfull  = 1'b0;
         e_seg    = '0;
         e_dp     = 1'b0;
         e_dig    = '0;
         e_tick   = 1'b0;
         e_ready  = 1'b1;
      end else begin
         pos   = s % PRE;
         dig   = (s / PRE) % NDIG;
         upper = m_shadow >> (4 * dig);
         if (pos >= BLK) begin
            e_dig = 4'(1 << dig);
            e_dp  = m_sdp[dig];
            e_seg = (lz_c && dig > 0 && upper == 16'h0) ? 7'h00 : seg_tab[4'(upper)];
         end else begin
            e_dig = '0;
            e_dp  = 1'b0;
            e_seg = '0;
         end
         e_tick = ((s + 1) % FRAME == 0);
         if (e_tick && m_pfull) begin
            m_shadow = m_pend;
            m_sdp    = m_pdp;
            m_pfull  = 1'b0;
         end
         if (v_c && e_ready) begin
            m_pend  = val_c;
            m_pdp   = dp_c;
            m_pfull = 1'b1;
         end
         e_ready = !m_pfull;
         s++;
      end
      #1;
      chk("dig_en", 16'(dig_en), 16'(e_dig));
      chk("seg_out", 16'(seg_out), 16'(e_seg));
      chk("dp_out", 16'(dp_out), 16'(e_dp));
      chk("frame_tick", 16'(frame_tick), 16'(e_tick));
      chk("load_ready", 16'(load_ready), 16'(e_ready));
   endtask

   task automatic wait_lit(input int dig);
      bit found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         tick();
         if (dig_en == 4'(1 << dig)) found = 1'b1;
      end
      n_checks++;
      assert (found)
      else begin
         n_err++;
         $error("FAIL wait_lit: observed no enable for digit %0d, expected it within %0d cycles", dig, 2 * FRAME);
      end
   endtask

   task automatic wait_frame();
      bit found = 1'b0;
      for (int i = 0; i < 2 * FRAME && !found; i++) begin
         tick();
         if (frame_tick) found = 1'b1;
      end
      n_checks++;
      assert (found)
      else begin
         n_err++;
         $error("FAIL wait_frame: observed no frame_tick, expected one within %0d cycles", 2 * FRAME);
      end
   endtask

   task automatic load(input logic [15:0] v, input logic [3:0] dp);
      bit done = 1'b0;
      bit was_ready;
      load_valid = 1'b1;
      value_in   = v;
      dp_in      = dp;
      for (int i = 0; i < 3 * FRAME && !done; i++) begin
         was_ready = load_ready;
         tick();
         if (was_ready) done = 1'b1;
      end
      load_valid = 1'b0;
      n_checks++;
      assert (done)
      else begin
         n_err++;
         $error("FAIL load: observed no acceptance of 0x%0h, expected within %0d cycles", v, 3 * FRAME);
      end
   endtask

   initial begin
      reset      = 1'b1;
      value_in   = '0;
      dp_in      = '0;
      load_valid = 1'b0;
      lzb_en     = 1'b0;
      s          = 0;
      e_ready    = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Idle scan after reset.
      for (int i = 1; i <= 64; i++) begin
         tick();
         if (i == 2)  chk("idle_blank", 16'(dig_en), 16'h0);
         if (i == 3)  chk("idle_dig0", 16'(dig_en), 16'h1);
         if (i == 8)  chk("idle_seg0", 16'(seg_out), 16'h3F);
         if (i == 9)  chk("idle_gap", 16'(dig_en), 16'h0);
         if (i == 11) chk("idle_dig1", 16'(dig_en), 16'h2);
         if (i == 32) chk("idle_tick", 16'(frame_tick), 16'h1);
      end

      // Mid-frame load shows only after the next frame boundary.
      for (int i = 0; i < 12; i++) tick();
      load(16'h1A2F, 4'b0100);
      chk("ld_ready_drop", 16'(load_ready), 16'h0);
      wait_frame();
      wait_lit(0); chk("ld_d0", 16'(seg_out), 16'h71); chk("ld_dp0", 16'(dp_out), 16'h0);
      wait_lit(1); chk("ld_d1", 16'(seg_out), 16'h5B);
      wait_lit(2); chk("ld_d2", 16'(seg_out), 16'h77); chk("ld_dp2", 16'(dp_out), 16'h1);
      wait_lit(3); chk("ld_d3", 16'(seg_out), 16'h06);

      // Back-to-back loads: the second producer stalls until the first commits.
      load(16'h1234, 4'b0000);
      load(16'h5555, 4'b0000);
      chk("stall_ready", 16'(load_ready), 16'h0);
      wait_lit(0); chk("stall_first", 16'(seg_out), 16'h66);
      wait_frame();
      wait_lit(0); chk("stall_second", 16'(seg_out), 16'h6D);

      // Leading-zero blanking.
      lzb_en = 1'b1;
      load(16'h0012, 4'b0000);
      wait_frame();
      wait_lit(0); chk("lzb_d0", 16'(seg_out), 16'h5B);
      wait_lit(1); chk("lzb_d1", 16'(seg_out), 16'h06);
      wait_lit(2); chk("lzb_d2", 16'(seg_out), 16'h00);
      wait_lit(3); chk("lzb_d3", 16'(seg_out), 16'h00);
      load(16'h0000, 4'b0000);
      wait_frame();
      wait_lit(0); chk("lzb_zero_d0", 16'(seg_out), 16'h3F);
      wait_lit(1); chk("lzb_zero_d1", 16'(seg_out), 16'h00);

      // Reset during digit-2 SHOW with a pending value.
      lzb_en = 1'b0;
      load(16'h9999, 4'b1111);
      wait_lit(2);
      chk("rst_pending", 16'(load_ready), 16'h0);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("rst_dig", 16'(dig_en), 16'h0);
      chk("rst_seg", 16'(seg_out), 16'h0);
      chk("rst_ready", 16'(load_ready), 16'h1);
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (i == 3)  chk("rst_restart", 16'(dig_en), 16'h1);
         if (i == 3)  chk("rst_no9", 16'(seg_out), 16'h3F);
         if (i == 32) chk("rst_tick", 16'(frame_tick), 16'h1);
      end

      // Random loads and blanking enable.
      for (int i = 0; i < 1200; i++) begin
         if (i % 50 == 0) lzb_en = 1'($urandom_range(0, 1));
         load_valid = ($urandom_range(0, 3) == 0);
         value_in   = ($urandom_range(0, 2) == 0) ? 16'($urandom_range(0, 255)) : 16'($urandom);
         dp_in      = 4'($urandom);
         tick();
      end
      load_valid = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule
